// File: rtl/lm70_pkg.sv
// rtl/lm70_pkg.sv - frame layout constants and FSM encoding for the LM70 SPI reader
package lm70_pkg;

   localparam int LM70_FRAME_BITS = 16;
   localparam int LM70_CODE_MSB   = 15;
   localparam int LM70_CODE_LSB   = 5;
   localparam int LM70_CODE_BITS  = LM70_CODE_MSB - LM70_CODE_LSB + 1;
   // Whole degrees are the code with its two fractional (0.25 C) bits dropped.
   localparam int LM70_DEG_LSB    = LM70_CODE_LSB + 2;
   localparam int LM70_DEG_BITS   = LM70_CODE_MSB - LM70_DEG_LSB + 1;
   localparam int LM70_ONES_MSB   = 4;
   localparam int LM70_ONES_LSB   = 2;
   localparam logic [2:0] LM70_ONES_FIELD = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SCK_HI,
      ST_SCK_LO,
      ST_HOLD
   } lm70_state_t;

   function automatic logic lm70_fmt_bad(input logic [2:0] ones);
      return ones != LM70_ONES_FIELD;
   endfunction

endpackage

// File: rtl/lm70_tick_gen.sv
// rtl/lm70_tick_gen.sv - HALF_PER phase timer shared by every timed FSM state
module lm70_tick_gen #(
   parameter int HALF_PER = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic tick
);

   localparam int CW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(HALF_PER - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);

   logic [CW-1:0] cnt;

   // load coincides with each state change, so every phase starts a full HALF_PER count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= RELOAD;
      end else if (cnt != '0) begin
         cnt <= cnt - ONE;
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/lm70_spi_reader.sv
// rtl/lm70_spi_reader.sv - 16-bit 3-wire SPI read master for the LM70 temperature sensor
module lm70_spi_reader
   import lm70_pkg::*;
#(
   parameter int HALF_PER = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             sio_in,
   output logic                             cs_n,
   output logic                             sck,
   output logic                             busy,
   output logic                             done,
   output logic [LM70_FRAME_BITS-1:0]       raw,
   output logic signed [LM70_CODE_BITS-1:0] temp_code,
   output logic signed [LM70_DEG_BITS-1:0]  temp_c,
   output logic                             fmt_err
);

   localparam int BIT_W = $clog2(LM70_FRAME_BITS);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(LM70_FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

   lm70_state_t                state;
   logic [LM70_FRAME_BITS-1:0] sr;
   logic [BIT_W-1:0]           bit_cnt;
   logic                       tick;
   logic                       load;

   assign load = (state == ST_IDLE) ? start : tick;

   lm70_tick_gen #(
      .HALF_PER (HALF_PER)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cs_n      <= 1'b1;
         sck       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sr        <= '0;
         bit_cnt   <= '0;
         raw       <= '0;
         temp_code <= '0;
         temp_c    <= '0;
         fmt_err   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_SETUP;
                  cs_n    <= 1'b0;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
               end
            end
            ST_SETUP: begin
               if (tick) begin
                  state <= ST_SCK_HI;
                  sck   <= 1'b1;
               end
            end
            ST_SCK_HI: begin
               // Sensor shifts on the falling edge, so the end of the high phase is the stable point.
               if (tick) begin
                  sr    <= {sr[LM70_FRAME_BITS-2:0], sio_in};
                  sck   <= 1'b0;
                  state <= ST_SCK_LO;
               end
            end
            ST_SCK_LO: begin
               if (tick) begin
                  if (bit_cnt != LAST_BIT) begin
                     bit_cnt <= bit_cnt + BIT_ONE;
                     sck     <= 1'b1;
                     state   <= ST_SCK_HI;
                  end else begin
                     cs_n  <= 1'b1;
                     state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (tick) begin
                  raw       <= sr;
                  temp_code <= $signed(sr[LM70_CODE_MSB:LM70_CODE_LSB]);
                  temp_c    <= $signed(sr[LM70_CODE_MSB:LM70_DEG_LSB]);
                  fmt_err   <= lm70_fmt_bad(sr[LM70_ONES_MSB:LM70_ONES_LSB]);
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               cs_n  <= 1'b1;
               sck   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // SCK may only be high while the sensor is selected.
   a_sck_in_frame: assert property (@(posedge clk) disable iff (rst) sck |-> !cs_n);
   a_done_idle:    assert property (@(posedge clk) disable iff (rst) done |-> !busy);

endmodule

// File: doc/lm70_spi_reader.md
# lm70_spi_reader

SPI read master for the LM70-family temperature sensor. It is the initiator side of the 3-wire link the sensor responds on. On a `start` request it drops `cs_n`, clocks out 16 SCK periods, and shifts in the sensor's MSB-first SIO frame. It then checks the frame's fixed-ones field and presents the raw frame, the 11-bit 0.25 °C code and whole degrees to the rest of `digital_temp_monitor_top`.

## Interface
Parameters:
- `HALF_PER`, default 2: SCK half-period in `clk` cycles; legal range ≥1.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: request one read; sampled only in IDLE.
- `sio_in` in 1: sensor SIO, sampled synchronously.
- `cs_n` out 1: sensor chip select, active low; reset 1.
- `sck` out 1: serial clock, idle low; reset 0.
- `busy` out 1: transaction in progress; reset 0.
- `done` out 1: one-cycle pulse when results update; reset 0.
- `raw` out 16: last received frame, D15 first; reset 16'h0000.
- `temp_code` out 11 signed: `raw[15:5]`, LSB = 0.25 °C; reset 0.
- `temp_c` out 9 signed: `temp_code >>> 2` (floor), range −256..255; reset 0.
- `fmt_err` out 1: `raw[4:2] != 3'b111` for the last frame; reset 0.

## Operation
- FSM states: IDLE → SETUP → SCK_HI ⇄ SCK_LO → HOLD → IDLE.
- **IDLE**
  - `cs_n`=1, `sck`=0, `busy`=0.
  - `start`=1 → SETUP; `cs_n`←0, `busy`←1, bit counter←0.
- **SETUP:** `cs_n` low for HALF_PER cycles before the first SCK rise. Gives the sensor time to present D15.
- **SCK_HI:** `sck`=1 for HALF_PER cycles. On the last edge of the phase:
  - shift register ← {sr[14:0], `sio_in`};
  - `sck`←0.
- **SCK_LO:** `sck`=0 for HALF_PER cycles. Then:
  - bit counter <15 → increment, go to SCK_HI;
  - otherwise → HOLD with `cs_n`←1.
- **HOLD:** `cs_n` high, `sck` low for HALF_PER cycles. Then:
  - → IDLE;
  - update `raw`, `temp_code`, `temp_c`, `fmt_err` together;
  - pulse `done`, `busy`←0.
- Output holding: result outputs hold their value between `done` pulses and never show partial frames.
- `start` is ignored while `busy`=1. It is not queued.
- `start` held high gives back-to-back reads.
- `fmt_err` is a status flag only. Results update regardless.
- Reset mid-transaction, on the next edge:
  - `cs_n`=1, `sck`=0, `busy`=0, FSM→IDLE;
  - all results cleared;
  - no `done` pulse.
- The sensor shifts on the falling SCK edge. Sampling at the end of the high phase therefore captures stable data.

## Timing
Let E0 be the edge at which `start` is accepted, and H = HALF_PER.
- `cs_n` falls and `busy` rises after E0.
- SCK rises at E0+H.
- Bit k (k=0 is D15) is sampled at E0+(2k+2)H; SCK falls at the same edge.
- Last sample at E0+32H.
- `cs_n` rises at E0+33H.
- Results update and `done`=1 for exactly one cycle at E0+34H; `busy` falls at the same edge.
- Next `start` can be accepted at E0+34H+1, so the back-to-back period is 34H+1 cycles.
- SCK runs at f_clk/(2H) with 50 % duty. Exactly 16 rising edges occur per transaction, all with `cs_n` low.

## Structure
- Package `lm70_pkg` holds:
  - `LM70_FRAME_BITS`=16, `LM70_CODE_MSB`=15, `LM70_CODE_LSB`=5;
  - `LM70_ONES_FIELD`=3'b111 at bits [4:2];
  - the FSM state enum.
- Sub-module `lm70_tick_gen`:
  - HALF_PER down-counter, reloaded on every state change;
  - asserts `tick` on the last cycle of each phase;
  - shared by SETUP, SCK_HI, SCK_LO and HOLD.

## Test plan
- Sensor model at −25 °C, H=2, single `start` pulse:
  - `done` at E0+68;
  - `raw`=16'hF39F, `temp_code`=−100, `temp_c`=−25, `fmt_err`=0;
  - 16 SCK rises within the `cs_n`-low window.
- Sensor at +25 °C:
  - `raw`=16'h0C9F, `temp_code`=100, `temp_c`=25.
- Sensor at 0 °C:
  - `raw`=16'h001F, `temp_c`=0.
- `sio_in` tied 0:
  - `raw`=16'h0000, `fmt_err`=1, `done` still pulses.
- `start` held high for 3 reads, H=1:
  - `done` pulses 35 cycles apart;
  - `start` pulses during `busy` cause no extra transaction.
- `rst` asserted at E0+20 (H=2):
  - next edge `cs_n`=1, `sck`=0, `busy`=0;
  - results zero, no `done`;
  - a fresh `start` afterwards reads correctly.
